bus_initiator_lsu: RTL

//  Initiator end of the valid/ready memory bus. Accepts one load/store request at a

---
 rtl/bus_initiator_lsu_pkg.sv | 26 ++
 rtl/bus_initiator_lsu_data_align.sv | 44 ++++
 rtl/bus_initiator_lsu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bus_initiator_lsu_pkg.sv
// Shared encodings for the load/store bus initiator: access sizes, store strobes,
// FSM states and a strobe-to-byte-mask helper.
package bus_initiator_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/bus_initiator_lsu_data_align.sv
// Combinational helpers: load-data extension from the low lanes, plus
// legality check and store strobe derivation for an incoming request.
module bus_initiator_lsu_data_align
  import bus_initiator_lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data,
  output logic        illegal,
  output logic [3:0]  wstrb
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ld_data = rdata;
    illegal = 1'b0;
    wstrb   = 4'b0000;

    case (size_e'(ld_size))
      SIZE_B:  ld_data = {{24{ld_signed & rdata[7]}}, rdata[7:0]};
      SIZE_H:  ld_data = {{16{ld_signed & rdata[15]}}, rdata[15:0]};
      default: ld_data = rdata;
    endcase

    case (size_e'(chk_size))
      SIZE_B: wstrb = WSTRB_B;
      SIZE_H: begin
        wstrb   = WSTRB_H;
        illegal = CHECK_ALIGN && chk_addr_lo[0];
      end
      SIZE_W: begin
        wstrb   = WSTRB_W;
        illegal = CHECK_ALIGN && (chk_addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bus_initiator_lsu.sv
// Initiator end of the valid/ready memory bus: takes one core load/store at a time,
// runs a single bus transaction with timeout, and returns extended data plus error.
module bus_initiator_lsu
  import bus_initiator_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        valid,
  input  logic        ready,
  input  logic [31:0] rdata,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  state_e          state;
  logic [CW-1:0]   tmo_cnt;
  logic [1:0]      size_q;
  logic            signed_q;
  logic            we_q;
  logic [31:0]     ld_data;
  logic            illegal;
  logic [3:0]      req_strb;

  bus_initiator_lsu_data_align #(
    .CHECK_ALIGN(CHECK_ALIGN)
  ) u_align (
    .chk_size    (req_size),
    .chk_addr_lo (req_addr[1:0]),
    .ld_size     (size_q),
    .ld_signed   (signed_q),
    .rdata       (rdata),
    .ld_data     (ld_data),
    .illegal     (illegal),
    .wstrb       (req_strb)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      valid     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      tmo_cnt   <= '0;
      size_q    <= SIZE_B;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr      <= req_addr;
            wdata     <= req_we ? (req_wdata & lane_mask(req_strb)) : '0;
            wstrb     <= req_we ? req_strb : 4'b0000;
            size_q    <= req_size;
            signed_q  <= req_signed;
            we_q      <= req_we;
            tmo_cnt   <= '0;
            req_ready <= 1'b0;
            if (illegal) begin
              // Rejected without touching the bus.
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= ST_BUS;
              valid <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A ready arriving on the timeout edge still completes normally.
          if (ready) begin
            valid     <= 1'b0;
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? '0 : ld_data;
          end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            valid     <= 1'b0;
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          valid     <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
